// File: rtl/wb_bus_master.sv
// Wishbone B3 classic-cycle initiator: turns one command into a single or incrementing
// burst access, streams write data in and read data out, and aborts stalled strobes.
module wb_bus_master #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 256
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [AW-1:0]     cmd_addr,
   input  logic [DW/8-1:0]   cmd_sel,
   input  logic [7:0]        cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DW-1:0]     wr_data,
   output logic              rd_valid,
   output logic [DW-1:0]     rd_data,
   output logic              done,
   output logic              err_timeout,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [AW-1:0]     wb_adr_o,
   output logic [DW/8-1:0]   wb_sel_o,
   output logic [DW-1:0]     wb_dat_o,
   output logic [2:0]        wb_cti_o,
   input  logic [DW-1:0]     wb_dat_i,
   input  logic              wb_ack_i
);
   // state  | meaning
   // IDLE   | waiting for a command, cmd_ready high
   // WDATA  | write beat pending, waiting for wr_valid with cyc held and stb low
   // STROBE | stb asserted, waiting for ack; timer counts down to abort

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WDATA, STROBE} state_t;

   state_t            state, state_n;
   logic [7:0]        beats, beats_n;
   logic [TW-1:0]     timer, timer_n;
   logic              cmd_ready_n, wr_ready_n, rd_valid_n, done_n, err_n;
   logic              cyc_n, stb_n, we_n;
   logic [AW-1:0]     adr_n;
   logic [DW/8-1:0]   sel_n;
   logic [DW-1:0]     dat_n, rd_data_n;
   logic [2:0]        cti_n;
   logic              ack;

   assign ack = wb_cyc_o && wb_stb_o && wb_ack_i;

   always_comb begin
      state_n   = state;
      beats_n   = beats;
      timer_n   = timer;
      cyc_n     = wb_cyc_o;
      stb_n     = wb_stb_o;
      we_n      = wb_we_o;
      adr_n     = wb_adr_o;
      sel_n     = wb_sel_o;
      dat_n     = wb_dat_o;
      cti_n     = wb_cti_o;
      rd_data_n = rd_data;
      rd_valid_n = 1'b0;
      done_n    = 1'b0;
      err_n     = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               adr_n   = cmd_addr;
               sel_n   = cmd_sel;
               we_n    = cmd_we;
               beats_n = cmd_len;
               cti_n   = (cmd_len == 8'd0) ? 3'b000 : 3'b010;
               cyc_n   = 1'b1;
               timer_n = T_LOAD;
               if (cmd_we) begin
                  stb_n   = 1'b0;
                  state_n = WDATA;
               end else begin
                  stb_n   = 1'b1;
                  state_n = STROBE;
               end
            end
         end
         WDATA: begin
            if (wr_valid) begin
               dat_n   = wr_data;
               stb_n   = 1'b1;
               timer_n = T_LOAD;
               state_n = STROBE;
            end
         end
         STROBE: begin
            if (ack) begin
               if (!wb_we_o) begin
                  rd_valid_n = 1'b1;
                  rd_data_n  = wb_dat_i;
               end
               if (beats == 8'd0) begin
                  cyc_n   = 1'b0;
                  stb_n   = 1'b0;
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  adr_n   = wb_adr_o + AW'(4);
                  beats_n = beats - 8'd1;
                  cti_n   = (beats == 8'd1) ? 3'b111 : 3'b010;
                  timer_n = T_LOAD;
                  if (wb_we_o) begin
                     stb_n   = 1'b0;
                     state_n = WDATA;
                  end
               end
            end else if (timer == '0) begin
               // ack in the final cycle takes the branch above, so it wins over abort
               cyc_n   = 1'b0;
               stb_n   = 1'b0;
               done_n  = 1'b1;
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      cmd_ready_n = (state_n == IDLE);
      wr_ready_n  = (state_n == WDATA);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         beats       <= '0;
         timer       <= '0;
         cmd_ready   <= 1'b0;
         wr_ready    <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= '0;
         wb_sel_o    <= '0;
         wb_dat_o    <= '0;
         wb_cti_o    <= '0;
      end else begin
         state       <= state_n;
         beats       <= beats_n;
         timer       <= timer_n;
         cmd_ready   <= cmd_ready_n;
         wr_ready    <= wr_ready_n;
         rd_valid    <= rd_valid_n;
         rd_data     <= rd_data_n;
         done        <= done_n;
         err_timeout <= err_n;
         wb_cyc_o    <= cyc_n;
         wb_stb_o    <= stb_n;
         wb_we_o     <= we_n;
         wb_adr_o    <= adr_n;
         wb_sel_o    <= sel_n;
         wb_dat_o    <= dat_n;
         wb_cti_o    <= cti_n;
      end
   end

endmodule
